// File: rtl/scalar_fetch_seq.sv
// Program sequencer feeding the scalar fetch stage: owns the PC, issues
// instruction-memory reads and flags returning instructions one cycle later.
module scalar_fetch_seq #(
  parameter int ADDR_W = 10,
  parameter int CNT_W  = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              I_Start,
  input  logic [ADDR_W-1:0] I_Start_PC,
  input  logic [ADDR_W-1:0] I_End_PC,
  input  logic              I_Stall,
  input  logic              I_Br_Taken,
  input  logic [ADDR_W-1:0] I_Br_Target,
  input  logic              I_Abort,
  output logic              O_IMem_Re,
  output logic [ADDR_W-1:0] O_IMem_Addr,
  output logic              O_Fetch_Req,
  output logic [ADDR_W-1:0] O_Fetch_PC,
  output logic              O_Term,
  output logic              O_Busy,
  output logic [CNT_W-1:0]  O_Instr_Cnt
);

  // state  | meaning
  // IDLE   | no program; waiting for I_Start
  // RUN    | issuing reads from PC
  // DRAIN  | last read returning; a branch here resumes the program
  // TERM   | one-cycle termination pulse
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_TERM} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [ADDR_W-1:0]   end_q, end_d;
  logic                r_valid_q, r_valid_d;
  logic [ADDR_W-1:0]   r_pc_q, r_pc_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                issue;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      pc_q      <= '0;
      end_q     <= '0;
      r_valid_q <= 1'b0;
      r_pc_q    <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      end_q     <= end_d;
      r_valid_q <= r_valid_d;
      r_pc_q    <= r_pc_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    end_d   = end_q;
    issue   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (I_Start) begin
          pc_d    = I_Start_PC;
          end_d   = I_End_PC;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (I_Abort) begin
          state_d = S_IDLE;
        end else if (I_Br_Taken) begin
          pc_d = I_Br_Target;
        end else if (!I_Stall) begin
          issue = 1'b1;
          if (pc_q == end_q) state_d = S_DRAIN;
          else               pc_d    = pc_q + 1'b1;
        end
      end
      S_DRAIN: begin
        if (I_Abort) begin
          state_d = S_IDLE;
        end else if (I_Br_Taken) begin
          pc_d    = I_Br_Target;
          state_d = S_RUN;
        end else begin
          state_d = S_TERM;
        end
      end
      S_TERM:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Fixed one-cycle memory latency: the flag simply trails the issue.
  always_comb begin
    r_valid_d = issue;
    r_pc_d    = issue ? pc_q : r_pc_q;
    cnt_d     = cnt_q;
    if (state_q == S_IDLE && I_Start) cnt_d = '0;
    else if (r_valid_q && cnt_q != '1) cnt_d = cnt_q + 1'b1;
  end

  assign O_IMem_Re   = issue;
  assign O_IMem_Addr = pc_q;
  assign O_Fetch_Req = r_valid_q;
  assign O_Fetch_PC  = r_pc_q;
  assign O_Term      = (state_q == S_TERM);
  assign O_Busy      = (state_q != S_IDLE);
  assign O_Instr_Cnt = cnt_q;

endmodule

// File: tb/tb_scalar_fetch_seq.sv
// Scoreboard bench for scalar_fetch_seq: directed programs push expected
// issue/fetch addresses; a negedge monitor pops and compares.
module tb_scalar_fetch_seq;

  localparam int ADDR_W = 10;
  localparam int CNT_W  = 16;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              I_Start = 1'b0;
  logic [ADDR_W-1:0] I_Start_PC = '0;
  logic [ADDR_W-1:0] I_End_PC = '0;
  logic              I_Stall = 1'b0;
  logic              I_Br_Taken = 1'b0;
  logic [ADDR_W-1:0] I_Br_Target = '0;
  logic              I_Abort = 1'b0;
  logic              O_IMem_Re;
  logic [ADDR_W-1:0] O_IMem_Addr;
  logic              O_Fetch_Req;
  logic [ADDR_W-1:0] O_Fetch_PC;
  logic              O_Term;
  logic              O_Busy;
  logic [CNT_W-1:0]  O_Instr_Cnt;

  scalar_fetch_seq #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset), .I_Start(I_Start), .I_Start_PC(I_Start_PC),
    .I_End_PC(I_End_PC), .I_Stall(I_Stall), .I_Br_Taken(I_Br_Taken),
    .I_Br_Target(I_Br_Target), .I_Abort(I_Abort), .O_IMem_Re(O_IMem_Re),
    .O_IMem_Addr(O_IMem_Addr), .O_Fetch_Req(O_Fetch_Req), .O_Fetch_PC(O_Fetch_PC),
    .O_Term(O_Term), .O_Busy(O_Busy), .O_Instr_Cnt(O_Instr_Cnt)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0;
  int term_cnt = 0;
  int term_cyc = 0;
  int last_iss_cyc = 0;
  logic [ADDR_W-1:0] exp_iss[$];
  logic [ADDR_W-1:0] exp_fet[$];

  always @(posedge clock) cyc++;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clock) begin
    if (O_IMem_Re) begin
      last_iss_cyc = cyc;
      if (exp_iss.size() == 0) chk("unexpected_issue", int'(O_IMem_Addr), -1);
      else chk("issue_addr", int'(O_IMem_Addr), int'(exp_iss.pop_front()));
    end
    if (O_Fetch_Req) begin
      if (exp_fet.size() == 0) chk("unexpected_fetch", int'(O_Fetch_PC), -1);
      else chk("fetch_pc", int'(O_Fetch_PC), int'(exp_fet.pop_front()));
    end
    if (O_Term) begin
      term_cnt++;
      term_cyc = cyc;
    end
  end

  task automatic push_range(input logic [ADDR_W-1:0] s, input int n);
    logic [ADDR_W-1:0] a;
    a = s;
    for (int i = 0; i < n; i++) begin
      exp_iss.push_back(a);
      exp_fet.push_back(a);
      a = a + 1'b1;
    end
  endtask

  task automatic start_prog(input logic [ADDR_W-1:0] s, input logic [ADDR_W-1:0] e);
    term_cnt = 0;
    @(posedge clock); #1;
    I_Start = 1'b1; I_Start_PC = s; I_End_PC = e;
    @(posedge clock); #1;
    I_Start = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (O_Busy && k < 200) begin
      @(posedge clock); #1;
      k++;
    end
    if (k >= 200) chk("idle_timeout", 1, 0);
  endtask

  task automatic end_checks(input string tag, input int term_exp, input int cnt_exp);
    chk({tag, "_term_cnt"}, term_cnt, term_exp);
    chk({tag, "_instr_cnt"}, int'(O_Instr_Cnt), cnt_exp);
    chk({tag, "_busy"}, int'(O_Busy), 0);
    chk({tag, "_iss_left"}, exp_iss.size(), 0);
    chk({tag, "_fet_left"}, exp_fet.size(), 0);
    exp_iss.delete();
    exp_fet.delete();
  endtask

  initial begin
    repeat (3) @(posedge clock);
    #1;
    chk("rst_re", int'(O_IMem_Re), 0);
    chk("rst_addr", int'(O_IMem_Addr), 0);
    chk("rst_freq", int'(O_Fetch_Req), 0);
    chk("rst_fpc", int'(O_Fetch_PC), 0);
    chk("rst_term", int'(O_Term), 0);
    chk("rst_busy", int'(O_Busy), 0);
    chk("rst_cnt", int'(O_Instr_Cnt), 0);
    reset = 1'b0;

    // Straight-line program 0x010..0x013
    push_range(10'h010, 4);
    start_prog(10'h010, 10'h013);
    wait_idle();
    chk("t1_term_lat", term_cyc - last_iss_cyc, 2);
    end_checks("t1", 1, 4);

    // Stall three cycles after the second issue
    push_range(10'h010, 4);
    start_prog(10'h010, 10'h013);
    @(posedge clock); #1;
    @(posedge clock); #1; I_Stall = 1'b1;
    repeat (3) begin @(posedge clock); #1; end
    I_Stall = 1'b0;
    wait_idle();
    end_checks("t2", 1, 4);

    // PC wrap at 2^ADDR_W
    push_range(10'h3FE, 4);
    start_prog(10'h3FE, 10'h001);
    wait_idle();
    end_checks("t3", 1, 4);

    // Branch (with stall also high) while PC=0x004
    push_range(10'h000, 4);
    push_range(10'h00A, 6);
    start_prog(10'h000, 10'h00F);
    repeat (4) begin @(posedge clock); #1; end
    chk("t4_pc_at_br", int'(O_IMem_Addr), 10'h004);
    I_Br_Taken = 1'b1; I_Br_Target = 10'h00A; I_Stall = 1'b1;
    @(posedge clock); #1;
    I_Br_Taken = 1'b0; I_Stall = 1'b0;
    wait_idle();
    end_checks("t4", 1, 10);

    // Abort in RUN; a second start during RUN is ignored
    push_range(10'h100, 3);
    start_prog(10'h100, 10'h1FF);
    @(posedge clock); #1; I_Start = 1'b1; I_Start_PC = 10'h200;
    @(posedge clock); #1; I_Start = 1'b0;
    @(posedge clock); #1; I_Abort = 1'b1;
    @(posedge clock); #1; I_Abort = 1'b0;
    chk("t5_busy_after_abort", int'(O_Busy), 0);
    repeat (4) begin @(posedge clock); #1; end
    end_checks("t5", 0, 3);

    // Single-instruction program
    push_range(10'h020, 1);
    start_prog(10'h020, 10'h020);
    wait_idle();
    end_checks("t6", 1, 1);

    // Branch during DRAIN resumes the program, then abort
    push_range(10'h020, 1);
    push_range(10'h030, 2);
    start_prog(10'h020, 10'h020);
    @(posedge clock); #1; I_Br_Taken = 1'b1; I_Br_Target = 10'h030;
    @(posedge clock); #1; I_Br_Taken = 1'b0;
    chk("t7_busy_rerun", int'(O_Busy), 1);
    @(posedge clock); #1;
    @(posedge clock); #1; I_Abort = 1'b1;
    @(posedge clock); #1; I_Abort = 1'b0;
    repeat (3) begin @(posedge clock); #1; end
    end_checks("t7", 0, 3);

    // Reset mid-program: no termination pulse, everything cleared
    push_range(10'h040, 2);
    exp_iss.push_back(10'h042);
    start_prog(10'h040, 10'h050);
    @(posedge clock); #1;
    @(posedge clock); #1; reset = 1'b1;
    @(posedge clock); #1; reset = 1'b0;
    chk("t8_busy_after_reset", int'(O_Busy), 0);
    repeat (3) begin @(posedge clock); #1; end
    end_checks("t8", 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/scalar_fetch_seq.md
Name: scalar_fetch_seq

Overview:
- Program sequencer in front of the scalar-unit fetch stage.
- Owns the program counter and issues read addresses to instruction memory.
- Flags each returning instruction to the fetch stage; applies downstream stall and branch redirects.
- Detects program end, signals termination, and reports completion to the TPU command controller.

Parameters:
- ADDR_W, 10, instruction memory address width; PC wraps modulo 2^ADDR_W.
- CNT_W, 16, width of the delivered-instruction counter.

Ports:
- clock  in  1  clock
- reset  in  1  reset, synchronous, active-high
- I_Start  in  1  start pulse, accepted only in IDLE
- I_Start_PC  in  ADDR_W  first instruction address
- I_End_PC  in  ADDR_W  last instruction address; sampled at start
- I_Stall  in  1  downstream buffer cannot accept; hold issue
- I_Br_Taken  in  1  redirect request from execute
- I_Br_Target  in  ADDR_W  redirect address
- I_Abort  in  1  kill program
- O_IMem_Re  out  1  instruction memory read enable
- O_IMem_Addr  out  ADDR_W  instruction memory read address (= PC)
- O_Fetch_Req  out  1  instruction on memory data bus is valid this cycle
- O_Fetch_PC  out  ADDR_W  address of instruction flagged by O_Fetch_Req
- O_Term  out  1  one-cycle termination pulse to fetch stage
- O_Busy  out  1  program active (state != IDLE)
- O_Instr_Cnt  out  CNT_W  delivered instructions since last start

Behaviour:
- Reset values: all outputs 0; state IDLE; PC 0; end register 0; counter 0.
- States: IDLE, RUN, DRAIN, TERM.
- Memory read latency is fixed at 1 cycle.
  - Issue at cycle t sets R_Valid and R_PC at t+1.
  - O_Fetch_Req = R_Valid; O_Fetch_PC = R_PC. Both are registered outputs.
- IDLE:
  - On I_Start: PC <= I_Start_PC, End <= I_End_PC, counter <= 0, go to RUN.
  - Start is ignored in every other state.
- RUN, each cycle, in priority order:
  1. I_Abort: go to IDLE, clear R_Valid, no issue.
  2. I_Br_Taken: no issue; PC <= I_Br_Target; R_Valid <= 0. The redirect squashes nothing already delivered.
  3. I_Stall: no issue; PC held.
  4. Otherwise: O_IMem_Re=1 and O_IMem_Addr=PC.
     - If PC == End, go to DRAIN.
     - Else PC <= PC+1, wrapping 2^ADDR_W-1 -> 0.
- O_IMem_Re is combinational from state and inputs; O_IMem_Addr = PC at all times.
- DRAIN:
  - Last read returns this cycle (R_Valid=1).
  - I_Abort: go to IDLE.
  - I_Br_Taken: PC <= I_Br_Target, go to RUN (program continues).
  - Otherwise go to TERM.
- TERM: O_Term=1 for exactly this cycle, then go to IDLE. O_Busy drops the cycle after TERM.
- Counter: increments on every cycle with O_Fetch_Req=1, saturating at 2^CNT_W-1. Held in IDLE, cleared on accepted start.
- Start with I_Start_PC == I_End_PC: one issue, then DRAIN, then TERM.
- Stall in the cycle after an issue does not cancel the returning instruction: O_Fetch_Req still asserts.
- I_Br_Taken and I_Stall together: branch wins; PC redirected with no issue.
- reset mid-program: return to IDLE next edge; no O_Term.
- Abort produces no O_Term.

Test Plan:
- Start PC=0x010, End=0x013, no stall: O_IMem_Re high 4 cycles at addrs 0x010..0x013. O_Fetch_Req 4 cycles, one cycle later, with matching O_Fetch_PC. O_Term pulses 2 cycles after the last issue. O_Instr_Cnt=4; O_Busy=0 afterwards.
- Same program with I_Stall high for 3 cycles after the second issue: addresses 0x012,0x013 issue after the stall. Exactly 4 Fetch_Req total, no duplicate PCs, count=4.
- Start PC=0x3FE, End=0x001, ADDR_W=10: issue order 0x3FE, 0x3FF, 0x000, 0x001, then O_Term.
- Start 0x000/End 0x00F; I_Br_Taken with target 0x00A while PC=0x004: no issue that cycle, next issue 0x00A. Run completes at 0x00F; count = 4+6 = 10.
- I_Abort in RUN: O_Busy=0 next cycle, no O_Term, no further Fetch_Req. A new I_Start asserted during RUN is ignored.
- Start with Start_PC=End=0x020: single issue, single Fetch_Req. Branch during DRAIN (target 0x030, End still 0x020) re-enters RUN.
